// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: field width, digit glyphs
// (active-high, ordered a..g) and the digit-count helper.
package seg7_pkg;

  localparam int FIELD_W = 6;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] BLANK   = 7'b0000000;

  function automatic int num_digits(input int num_fields);
    return 2 * num_fields;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Source/display bundle between a time source and the scan driver.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int NUM_FIELDS = 3
);
  logic [FIELD_W*NUM_FIELDS-1:0] src_a;
  logic [FIELD_W*NUM_FIELDS-1:0] src_b;
  logic                          src_sel;
  logic [NUM_FIELDS-1:0]         blink_mask;
  logic                          sec_tick;
  logic [6:0]                    seg;
  logic                          dp;
  logic [2*NUM_FIELDS-1:0]       an;

  modport master (
    output src_a, src_b, src_sel, blink_mask, sec_tick,
    input  seg, dp, an
  );

  modport slave (
    input  src_a, src_b, src_sel, blink_mask, sec_tick,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_encode.sv
// Decimal digit to active-high 7-segment glyph; anything above 9 is blank.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = BLANK;
    case (i_digit)
      4'd0:    o_glyph = GLYPH_0;
      4'd1:    o_glyph = GLYPH_1;
      4'd2:    o_glyph = GLYPH_2;
      4'd3:    o_glyph = GLYPH_3;
      4'd4:    o_glyph = GLYPH_4;
      4'd5:    o_glyph = GLYPH_5;
      4'd6:    o_glyph = GLYPH_6;
      4'd7:    o_glyph = GLYPH_7;
      4'd8:    o_glyph = GLYPH_8;
      4'd9:    o_glyph = GLYPH_9;
      default: o_glyph = BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 2-digit-per-field 7-segment driver with frame-aligned source
// snapshot, per-field blinking, colon flashing and optional leading-zero blank.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_FIELDS   = 3,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1,
  parameter int LZB          = 0
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int NUM_DIG = num_digits(NUM_FIELDS);
  localparam int DIV_W   = $clog2(REFRESH_DIV);
  localparam int DIG_W   = $clog2(NUM_DIG);
  localparam int BLK_W   = $clog2(BLINK_FRAMES + 1);
  localparam bit POL     = (ACTIVE_LOW != 0);
  localparam bit LZB_EN  = (LZB != 0);

  logic [DIV_W-1:0]              r_div_cnt;
  logic [DIG_W-1:0]              r_dig;
  logic [BLK_W-1:0]              r_blink_cnt;
  logic                          r_blink_ph;
  logic                          r_colon_ph;
  logic [FIELD_W*NUM_FIELDS-1:0] r_snap;
  logic [6:0]                    r_seg;
  logic                          r_dp;
  logic [NUM_DIG-1:0]            r_an;

  logic [FIELD_W-1:0] w_fields [NUM_FIELDS];
  logic [DIG_W-2:0]   w_field_idx;
  logic [FIELD_W-1:0] w_val;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;
  logic [3:0]         w_digit;
  logic [6:0]         w_glyph;
  logic               w_blink_off;
  logic               w_lz_off;
  logic [6:0]         w_seg;
  logic               w_dp;
  logic [NUM_DIG-1:0] w_an;
  logic               w_div_last;
  logic               w_dig_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      assign w_fields[gi] = r_snap[gi*FIELD_W +: FIELD_W];
    end
    // Slot's first cycle is dark so the previous digit never ghosts onto the next anode.
    for (gi = 0; gi < NUM_DIG; gi++) begin : g_an
      assign w_an[gi] = (r_div_cnt != '0) && (r_dig == DIG_W'(gi));
    end
  endgenerate

  assign w_field_idx = r_dig[DIG_W-1:1];
  assign w_val       = w_fields[w_field_idx];
  assign w_tens      = 4'(w_val / 6'd10);
  assign w_ones      = 4'(w_val % 6'd10);
  assign w_digit     = r_dig[0] ? w_tens : w_ones;

  seg7_encode u_encode (
    .i_digit (w_digit),
    .o_glyph (w_glyph)
  );

  assign w_blink_off = r_blink_ph && bus.blink_mask[w_field_idx];
  assign w_lz_off    = LZB_EN && (r_dig == DIG_W'(NUM_DIG-1)) && (w_tens == 4'd0);
  assign w_seg       = (w_blink_off || w_lz_off) ? BLANK : w_glyph;
  assign w_dp        = r_colon_ph && !r_dig[0] && (w_field_idx != '0) && !w_blink_off;
  assign w_div_last  = (r_div_cnt == DIV_W'(REFRESH_DIV-1));
  assign w_dig_last  = (r_dig == DIG_W'(NUM_DIG-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_dig       <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_colon_ph  <= 1'b0;
      r_snap      <= '0;
      r_seg       <= {7{POL}};
      r_dp        <= POL;
      r_an        <= {NUM_DIG{POL}};
    end else begin
      r_colon_ph <= r_colon_ph ^ bus.sec_tick;
      if (w_div_last) begin
        r_div_cnt <= '0;
        if (w_dig_last) begin
          // Frame start: latch the source and step the blink phase together.
          r_dig  <= '0;
          r_snap <= bus.src_sel ? bus.src_b : bus.src_a;
          if (r_blink_cnt == BLK_W'(BLINK_FRAMES-1)) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end else begin
          r_dig <= r_dig + 1'b1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      r_seg <= w_seg ^ {7{POL}};
      r_dp  <= w_dp ^ POL;
      r_an  <= w_an ^ {NUM_DIG{POL}};
    end
  end

  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;
  assign bus.an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: one LZB=0 and one LZB=1 instance fed the same
// stimulus, compared every cycle against a position-based display model.
module tb_seg7_scan_driver;

  localparam int NF = 3;
  localparam int R  = 4;
  localparam int BF = 2;
  localparam int ND = 2 * NF;
  localparam int FR = R * ND;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [6*NF-1:0] src_a = '0;
  logic [6*NF-1:0] src_b = '0;
  logic            src_sel = 1'b0;
  logic [NF-1:0]   blink_mask = '0;
  logic            sec_tick = 1'b0;

  int checks = 0;
  int errors = 0;

  int m_pos = 0;
  int m_field [NF];
  bit m_colon = 1'b0;

  logic [6:0] glyph [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  seg7_scan_driver_if #(.NUM_FIELDS(NF)) if0 ();
  seg7_scan_driver_if #(.NUM_FIELDS(NF)) if1 ();

  assign if0.src_a = src_a;      assign if1.src_a = src_a;
  assign if0.src_b = src_b;      assign if1.src_b = src_b;
  assign if0.src_sel = src_sel;  assign if1.src_sel = src_sel;
  assign if0.blink_mask = blink_mask;  assign if1.blink_mask = blink_mask;
  assign if0.sec_tick = sec_tick;      assign if1.sec_tick = sec_tick;

  seg7_scan_driver #(.NUM_FIELDS(NF), .REFRESH_DIV(R), .BLINK_FRAMES(BF),
                     .ACTIVE_LOW(0), .LZB(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  seg7_scan_driver #(.NUM_FIELDS(NF), .REFRESH_DIV(R), .BLINK_FRAMES(BF),
                     .ACTIVE_LOW(0), .LZB(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at pos %0d", tag, obs, exp, m_pos);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_colon = 1'b0;
    for (int i = 0; i < NF; i++) m_field[i] = 0;
  endtask

  // One clock: predict outputs from the scan position before the edge, then compare.
  task automatic step();
    int p, c, d, fr, f, v, dg;
    bit blk, lz;
    logic [6:0] e_seg0, e_seg1;
    logic e_dp;
    logic [ND-1:0] e_an;
    p  = m_pos;
    c  = p % R;
    d  = (p / R) % ND;
    fr = p / FR;
    f  = d / 2;
    v  = m_field[f];
    dg = (d % 2 == 1) ? v / 10 : v % 10;
    blk = ((fr / BF) % 2 == 1) && blink_mask[f];
    lz  = (d == ND - 1) && (v / 10 == 0);
    e_an   = (c == 0) ? '0 : ND'(1 << d);
    e_seg0 = blk ? 7'h00 : glyph[dg];
    e_seg1 = (blk || lz) ? 7'h00 : glyph[dg];
    e_dp   = m_colon && (d % 2 == 0) && (f >= 1) && !blk;
    if (c == R - 1 && d == ND - 1)
      for (int i = 0; i < NF; i++)
        m_field[i] = int'(src_sel ? src_b[6*i +: 6] : src_a[6*i +: 6]);
    if (sec_tick) m_colon = !m_colon;
    m_pos++;
    @(posedge clk);
    #1;
    chk("an0", 32'(if0.an), 32'(e_an));
    chk("seg0", 32'(if0.seg), 32'(e_seg0));
    chk("dp0", 32'(if0.dp), 32'(e_dp));
    chk("an1", 32'(if1.an), 32'(e_an));
    chk("seg1", 32'(if1.seg), 32'(e_seg1));
    chk("dp1", 32'(if1.dp), 32'(e_dp));
    $display("pos=%0d dig=%0d an=%b seg0=%b seg1=%b dp=%b", p, d, if0.an, if0.seg, if1.seg, if0.dp);
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an0"}, 32'(if0.an), 32'd0);
    chk({tag, "_seg0"}, 32'(if0.seg), 32'd0);
    chk({tag, "_dp0"}, 32'(if0.dp), 32'd0);
    chk({tag, "_an1"}, 32'(if1.an), 32'd0);
    chk({tag, "_seg1"}, 32'(if1.seg), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_dark("reset");
    src_a = {6'd12, 6'd34, 6'd56};
    rst = 1'b0;

    // Frame 0 shows the cleared snapshot, frame 1 shows 12:34:56.
    repeat (2 * FR) step();

    // Source switch mid-frame only lands at the next frame.
    repeat (10) step();
    src_b = {6'd0, 6'd1, 6'd59};
    src_sel = 1'b1;
    repeat (2 * FR) step();

    // Minutes blink.
    blink_mask = 3'b010;
    repeat (5 * FR) step();
    blink_mask = '0;

    // Colon ticks, 10 apart then 40 apart.
    sec_tick = 1'b1; step(); sec_tick = 1'b0;
    repeat (9) step();
    sec_tick = 1'b1; step(); sec_tick = 1'b0;
    repeat (5) step();
    sec_tick = 1'b1; step(); sec_tick = 1'b0;
    repeat (39) step();
    sec_tick = 1'b1; step(); sec_tick = 1'b0;

    // Leading-zero blanking with hours 5 and 0.
    src_sel = 1'b0;
    src_a = {6'd5, 6'd7, 6'd8};
    repeat (2 * FR + 3) step();
    src_a = {6'd0, 6'd9, 6'd10};
    repeat (2 * FR) step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        src_a[6*$urandom_range(0, NF-1) +: 6] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0)
        src_b[6*$urandom_range(0, NF-1) +: 6] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) src_sel = ~src_sel;
      if ($urandom_range(0, 63) == 0) blink_mask = NF'($urandom);
      sec_tick = ($urandom_range(0, 9) == 0);
      step();
    end
    sec_tick = 1'b0;

    // Reset in the middle of digit 3's slot (div_cnt = 2).
    for (int i = 0; i < FR && (m_pos % FR) != 3 * R + 2; i++) step();
    chk("mid_pos", 32'(m_pos % FR), 32'(3 * R + 2));
    rst = 1'b1;
    #1;
    check_dark("midrst");
    model_reset();
    @(posedge clk);
    #1;
    check_dark("midrst_hold");
    rst = 1'b0;
    step();
    chk("post_rst_blank", 32'(if0.an), 32'd0);
    step();
    chk("post_rst_first", 32'(if0.an), 32'd1);
    repeat (2 * FR) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 3: number of 2-digit fields (seconds, minutes, hours).
REQ-002 SHALL have parameter REFRESH_DIV, default 1000: clk cycles per digit slot, >=4.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: scan frames per blink half-period.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = segments and anodes driven active-low.
REQ-005 SHALL have parameter LZB, default 0: 1 = blank the leading tens digit of the top field when it is zero.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 src_a  input  6*NUM_FIELDS  current-time fields; field f is bits [6f+5:6f]; field 0 is seconds.
REQ-009 src_b  input  6*NUM_FIELDS  stopwatch fields, same packing.
REQ-010 src_sel  input  1  0 = display src_a, 1 = display src_b.
REQ-011 blink_mask  input  NUM_FIELDS  1 = field f blinks (set mode).
REQ-012 sec_tick  input  1  single-cycle pulse, once per second.
REQ-013 seg  output  7  segments {a,b,c,d,e,f,g}, registered.
REQ-014 dp  output  1  decimal point / colon segment, registered.
REQ-015 an  output  2*NUM_FIELDS  digit enables, at most one active; registered.

Function
REQ-016 Divider div_cnt SHALL count 0..REFRESH_DIV-1 and wrap; its terminal count SHALL advance digit index dig from 0..2*NUM_FIELDS-1, wrapping to 0.
REQ-017 Digit 2f SHALL show the ones digit of field f, and digit 2f+1 its tens digit.
REQ-018 When dig wraps to 0 (frame start), the block SHALL snapshot the src_a or src_b vector selected by src_sel; mid-frame src_sel or source changes SHALL take effect only at the next frame start.
REQ-019 Each field value SHALL be converted as tens = v/10, ones = v%10; a value >99 (not reachable at 6 bits) or a digit >9 SHALL display all segments off.
REQ-020 Segment encoding SHALL be the standard active-high glyphs 0-9 (0 = 1111110, 1 = 0110000, ... 9 = 1111011, ordered a..g), inverted when ACTIVE_LOW=1.
REQ-021 During div_cnt==0 of every slot, all anodes SHALL be inactive (anti-ghost blanking); during div_cnt 1..REFRESH_DIV-1, only an[dig] SHALL be active.
REQ-022 blink_cnt SHALL count frames; every BLINK_FRAMES frames blink_ph SHALL toggle; while blink_ph=1 and blink_mask[f]=1, both digits of field f SHALL show segments off and dp off.
REQ-023 Each sec_tick SHALL toggle colon_ph; dp SHALL be lit on digit 2f for f>=1 while colon_ph=1, and off otherwise.
REQ-024 With LZB=1, digit 2*NUM_FIELDS-1 SHALL show segments off when its tens value is 0.
REQ-025 seg, dp and an SHALL update one clk after the dig/div_cnt values that select them.
REQ-026 sec_tick coincident with a frame start SHALL be honoured (toggle) with no lost events.

Reset
REQ-027 While rst=1: div_cnt, dig, blink_cnt = 0; blink_ph, colon_ph = 0; snapshot = 0; seg and dp off; an all inactive (polarity per ACTIVE_LOW).
REQ-028 Reset asserted mid-slot SHALL take effect immediately; after release, scanning SHALL restart at dig=0 with a blanking cycle; rst SHALL take precedence over a coincident sec_tick.

Structure
REQ-029 Package seg7_pkg SHALL hold the glyph constants (digits 0-9, BLANK), the field width constant FIELD_W=6 and the digit-count function.
REQ-030 Combinational sub-module seg7_encode (4-bit digit in, 7-bit active-high glyph out) SHALL be used; the polarity inversion stays in the top level.

Verification (NUM_FIELDS=3, REFRESH_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=0)
REQ-031 src_sel=0, src_a={h=12,m=34,s=56}: over one frame, an walks 000001->100000; seg = glyph 6,5,4,3,2,1; an=0 on each div_cnt==0 cycle.
REQ-032 Change src_sel 0->1 mid-frame, with src_b={0,1,59}: the current frame is unchanged; the next frame shows 9,5,1,0,0,0.
REQ-033 blink_mask=3'b010: minutes digits blank for 2 frames, then visible for 2 frames, repeating; seconds/hours are never blanked.
REQ-034 Pulse sec_tick twice, 10 cycles apart: dp lit on digits 2 and 4 only, between the first and second tick.
REQ-035 LZB=1, h=5: digit 5 blank and digit 4 = glyph 5; h=0: digit 5 blank and digit 4 = glyph 0.
REQ-036 Assert rst on div_cnt=2 of dig=3: seg=0, an=0 in the same cycle; after release, the first active an=000001 occurs on the 2nd cycle.
